// File: rtl/gray_conv_pkg.sv
// Shared types and helpers for the Gray-to-binary conversion scheduler.
// Step-check history is enabled by defining GRAY_CONV_STEP_CHECK_EN.
package gray_conv_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    localparam int MAX_W = 64;

    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int k = MAX_W - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    function automatic logic is_one_step(input logic [MAX_W-1:0] a,
                                         input logic [MAX_W-1:0] b);
        return $countones(a ^ b) <= 1;
    endfunction

endpackage

// File: rtl/gray_conv_scheduler_core.sv
// Purely combinational Gray-to-binary converter, one per scheduler.
// Shared by all requesters through the grant mux in the top.
module gray_to_bin_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    always_comb begin
        bin_o = '0;
        bin_o[WIDTH-1] = gray_i[WIDTH-1];
        for (int k = WIDTH - 2; k >= 0; k--) begin
            bin_o[k] = bin_o[k+1] ^ gray_i[k];
        end
    end

endmodule

// File: rtl/gray_conv_scheduler.sv
// Round-robin scheduler sharing one Gray-to-binary converter among requesters.
// Optional per-requester Gray step check under GRAY_CONV_STEP_CHECK_EN.
module gray_conv_scheduler
    import gray_conv_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4,
    parameter int ID_W  = id_w(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_gray,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    output logic [WIDTH-1:0]       rsp_binary,
    output logic [ID_W-1:0]        rsp_id,
    input  logic                   rsp_ready,
    output logic [N_REQ-1:0]       err_flag,
    input  logic                   err_clr
);

    state_e           state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [ID_W-1:0]  id_q, id_d;

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  gid;
    logic             found;
    logic [WIDTH-1:0] sel_gray;
    logic [WIDTH-1:0] conv;
    logic             can_load;
    logic             accept;

    // Scan upward from rr_ptr with wrap; first valid requester wins.
    always_comb begin
        int        idx;
        logic [ID_W-1:0] idx_s;
        grant = '0;
        gid   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            idx_s = ID_W'(idx);
            if (!found && req_valid[idx_s]) begin
                grant[idx_s] = 1'b1;
                gid          = idx_s;
                found        = 1'b1;
            end
        end
    end

    assign sel_gray  = req_gray[int'(gid)*WIDTH +: WIDTH];
    assign can_load  = (state_q == EMPTY) | rsp_ready;
    assign accept    = found & can_load;
    assign req_ready = grant & {N_REQ{can_load & rst_n}};

    gray_to_bin_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .gray_i (sel_gray),
        .bin_o  (conv)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        bin_d    = bin_q;
        id_d     = id_q;
        if (accept) begin
            state_d  = FULL;
            bin_d    = conv;
            id_d     = gid;
            rr_ptr_d = (int'(gid) == N_REQ - 1) ? '0 : gid + 1'b1;
        end else if (rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            rr_ptr_q <= '0;
            bin_q    <= '0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            bin_q    <= bin_d;
            id_q     <= id_d;
        end
    end

    assign rsp_valid  = (state_q == FULL);
    assign rsp_binary = bin_q;
    assign rsp_id     = id_q;

`ifdef GRAY_CONV_STEP_CHECK_EN
    logic [N_REQ-1:0][WIDTH-1:0] last_q, last_d;
    logic [N_REQ-1:0]            seen_q, seen_d;
    logic [N_REQ-1:0]            err_q, err_d;

    // A new error in the same cycle as err_clr still sets its bit.
    always_comb begin
        last_d = last_q;
        seen_d = seen_q;
        err_d  = err_clr ? '0 : err_q;
        if (accept) begin
            last_d[gid] = sel_gray;
            seen_d[gid] = 1'b1;
            if (seen_q[gid] &&
                !is_one_step(MAX_W'(sel_gray), MAX_W'(last_q[gid]))) begin
                err_d[gid] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '0;
            seen_q <= '0;
            err_q  <= '0;
        end else begin
            last_q <= last_d;
            seen_q <= seen_d;
            err_q  <= err_d;
        end
    end

    assign err_flag = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_flag       = '0;
`endif

endmodule

// File: tb/tb_gray_conv_scheduler.sv
// Self-checking bench for gray_conv_scheduler: scoreboard plus directed steps.
// Expects err_flag activity only when GRAY_CONV_STEP_CHECK_EN is defined.
module tb_gray_conv_scheduler;

    localparam int W = 8;
    localparam int N = 4;
`ifdef GRAY_CONV_STEP_CHECK_EN
    localparam logic [3:0] EXP_ERR = 4'b1000;
`else
    localparam logic [3:0] EXP_ERR = 4'b0000;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_gray;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic [W-1:0]   rsp_binary;
    logic [1:0]     rsp_id;
    logic           rsp_ready;
    logic [N-1:0]   err_flag;
    logic           err_clr;

    always #5 clk = ~clk;

    gray_conv_scheduler #(.WIDTH(W), .N_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_gray   (req_gray),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_binary (rsp_binary),
        .rsp_id     (rsp_id),
        .rsp_ready  (rsp_ready),
        .err_flag   (err_flag),
        .err_clr    (err_clr)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0] id;
        logic [7:0] bin;
    } exp_t;
    exp_t sb[$];

    logic       m_full;
    logic [1:0] m_rr;
    logic [3:0] mon_eg;
    logic       mon_can;
    logic       mon_hit;
    int         mon_id;
    int         mon_idx;
    exp_t       mon_e;

    function automatic logic [7:0] tb_g2b(input logic [7:0] g);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int i, input logic [7:0] w);
        req_gray[i*8 +: 8] = w;
    endtask

    // Reference model and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            sb.delete();
            m_full = 1'b0;
            m_rr   = 2'd0;
        end else begin
            mon_eg  = '0;
            mon_hit = 1'b0;
            mon_id  = 0;
            for (int k = 0; k < N; k++) begin
                mon_idx = (int'(m_rr) + k) % N;
                if (!mon_hit && req_valid[mon_idx]) begin
                    mon_eg[mon_idx] = 1'b1;
                    mon_hit = 1'b1;
                    mon_id  = mon_idx;
                end
            end
            mon_can = !m_full || rsp_ready;
            chk("req_ready", 32'(req_ready), mon_can ? 32'(mon_eg) : 0);
            chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
            if (m_full && rsp_ready) begin
                n_cmp++;
                assert (sb.size() > 0) else begin
                    n_err++;
                    $error("FAIL sb_underflow: observed 0 entries expected 1");
                end
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    chk("sb_rsp_id", 32'(rsp_id), 32'(mon_e.id));
                    chk("sb_rsp_binary", 32'(rsp_binary), 32'(mon_e.bin));
                end
            end
            if (mon_hit && mon_can) begin
                sb.push_back('{2'(mon_id), tb_g2b(req_gray[mon_id*8 +: 8])});
                m_full = 1'b1;
                m_rr   = 2'((mon_id + 1) % N);
            end else if (rsp_ready) begin
                m_full = 1'b0;
            end
        end
    end

    initial begin
        logic [7:0] g;
        rst_n     = 1'b0;
        req_valid = '0;
        req_gray  = '0;
        rsp_ready = 1'b0;
        err_clr   = 1'b0;
        set_word(0, 8'h81);
        set_word(1, 8'h00);
        set_word(2, 8'hC6);
        set_word(3, 8'h00);
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_rsp_id", 32'(rsp_id), 0);
        chk("reset_rsp_binary", 32'(rsp_binary), 0);
        chk("reset_err_flag", 32'(err_flag), 0);
        chk("reset_req_ready", 32'(req_ready), 0);
        repeat (2) step();
        rst_n = 1'b1;

        // Round-robin with all requesters valid
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_valid", 32'(rsp_valid), 1);
            chk("rr_id", 32'(rsp_id), i % 4);
        end
        req_valid = '0;
        step();

        // Single request from requester 2
        req_valid = 4'b0100;
        step();
        chk("single_valid", 32'(rsp_valid), 1);
        chk("single_id", 32'(rsp_id), 2);
        chk("single_bin", 32'(rsp_binary), 32'h84);
        req_valid = '0;
        step();

        // Backpressure: requester 3 is next in line
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        step();
        chk("bp_first_id", 32'(rsp_id), 3);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_req_ready", 32'(req_ready), 0);
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_id", 32'(rsp_id), 3);
            chk("bp_bin", 32'(rsp_binary), 32'h00);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'b0001);
        step();
        chk("bp_next_id", 32'(rsp_id), 0);
        chk("bp_next_bin", 32'(rsp_binary), 32'h81 ^ 32'h7F);
        req_valid = '0;
        step();

        // Conversion sweep on requester 1
        req_valid = 4'b0010;
        for (int n = 0; n < 256; n++) begin
            g = 8'(n ^ (n >> 1));
            set_word(1, g);
            step();
            chk("sweep_bin", 32'(rsp_binary), n);
            chk("sweep_id", 32'(rsp_id), 1);
        end
        req_valid = '0;
        step();

        // Step check on requester 3
        req_valid = 4'b1000;
        set_word(3, 8'h00);
        step();
        chk("step_w1", 32'(err_flag), 0);
        set_word(3, 8'h01);
        step();
        chk("step_w2", 32'(err_flag), 0);
        set_word(3, 8'h02);
        step();
        chk("step_w3", 32'(err_flag), 32'(EXP_ERR));
        req_valid = '0;
        err_clr   = 1'b1;
        step();
        err_clr = 1'b0;
        chk("step_clr", 32'(err_flag), 0);

        // Reset while FULL with an error flagged
        set_word(3, 8'h07);
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        step();
        chk("mid_full_valid", 32'(rsp_valid), 1);
        chk("mid_full_err", 32'(err_flag), 32'(EXP_ERR));
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(rsp_valid), 0);
        chk("async_rst_ready", 32'(req_ready), 0);
        chk("async_rst_err", 32'(err_flag), 0);
        step();
        step();
        rst_n     = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'b0001);
        step();
        chk("post_rst_id", 32'(rsp_id), 0);
        chk("post_rst_valid", 32'(rsp_valid), 1);
        req_valid = '0;
        step();
        step();
        chk("sb_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
